// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage control-flow resolution.
// Resolves conditional branches, JAL and JALR, checks them against the fetch
// prediction, registers a one-cycle redirect pulse and owns the 2-bit BHT
// that fetch reads, plus branch/mispredict statistics counters.
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_IDX_W = 6,
    parameter int CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [XLEN-1:0]  fetch_pc_i,
    output logic             pred_taken_o,
    input  logic             valid_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  operand1_i,
    input  logic [XLEN-1:0]  operand2_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic [6:0]       opcode_i,
    input  logic [2:0]       funct3_i,
    input  logic             pred_taken_i,
    input  logic [XLEN-1:0]  pred_target_i,
    output logic             res_valid_o,
    output logic             taken_o,
    output logic             mispredict_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic [XLEN-1:0]  link_o,
    output logic             misaligned_o,
    output logic [CNT_W-1:0] branch_count_o,
    output logic [CNT_W-1:0] mispred_count_o
);

    localparam int         BHT_ENTRIES = 1 << BHT_IDX_W;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;

    logic [1:0]           bht [BHT_ENTRIES];
    logic [BHT_IDX_W-1:0] ex_idx;
    logic [BHT_IDX_W-1:0] fetch_idx;
    logic                 is_branch;
    logic                 is_jump;
    logic                 accept;
    logic                 cond_taken;
    logic                 actual_taken;
    logic                 bht_update;
    logic [XLEN-1:0]      target;
    logic [XLEN-1:0]      fallthrough;
    logic                 target_misaligned;
    logic                 mispredict;
    logic                 unused_bits;

    assign fetch_idx    = fetch_pc_i[BHT_IDX_W+1:2];
    assign ex_idx       = pc_i[BHT_IDX_W+1:2];
    assign pred_taken_o = bht[fetch_idx][1];
    assign unused_bits  = ^{fetch_pc_i[XLEN-1:BHT_IDX_W+2], fetch_pc_i[1:0]};

    // Decode the EX instruction, evaluate its condition and form target/redirect data.
    always_comb begin
        is_branch  = (opcode_i == OP_BRANCH);
        is_jump    = (opcode_i == OP_JAL) || (opcode_i == OP_JALR);
        accept     = valid_i && !stall_i && !flush_i && (is_branch || is_jump);
        cond_taken = 1'b0;
        case (funct3_i)
            3'b000:  cond_taken = (operand1_i == operand2_i);
            3'b001:  cond_taken = (operand1_i != operand2_i);
            3'b100:  cond_taken = ($signed(operand1_i) <  $signed(operand2_i));
            3'b101:  cond_taken = ($signed(operand1_i) >= $signed(operand2_i));
            3'b110:  cond_taken = (operand1_i <  operand2_i);
            3'b111:  cond_taken = (operand1_i >= operand2_i);
            default: cond_taken = 1'b0;
        endcase
        actual_taken = is_jump || cond_taken;
        bht_update   = accept && is_branch && (funct3_i != 3'b010) && (funct3_i != 3'b011);
        fallthrough  = pc_i + XLEN'(4);
        if (opcode_i == OP_JALR) begin
            target = (operand1_i + imm_i) & ~XLEN'(1);
        end else begin
            target = pc_i + imm_i;
        end
        target_misaligned = actual_taken && target[1];
        mispredict        = !target_misaligned &&
                            ((actual_taken != pred_taken_i) ||
                             (actual_taken && (target != pred_target_i)));
    end

    // Register the resolution: pulses every cycle, data only on accept, counters on accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_valid_o     <= 1'b0;
            mispredict_o    <= 1'b0;
            taken_o         <= 1'b0;
            misaligned_o    <= 1'b0;
            redirect_pc_o   <= '0;
            link_o          <= '0;
            branch_count_o  <= '0;
            mispred_count_o <= '0;
        end else begin
            res_valid_o  <= accept;
            mispredict_o <= accept && mispredict;
            if (accept) begin
                taken_o        <= actual_taken;
                misaligned_o   <= target_misaligned;
                redirect_pc_o  <= actual_taken ? target : fallthrough;
                link_o         <= fallthrough;
                branch_count_o <= branch_count_o + CNT_W'(1);
                if (mispredict) begin
                    mispred_count_o <= mispred_count_o + CNT_W'(1);
                end
            end
        end
    end

    // BHT: all entries weakly not-taken on reset, saturating update on resolved conditional branches.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (bht_update) begin
            if (cond_taken) begin
                if (bht[ex_idx] != 2'b11) begin
                    bht[ex_idx] <= bht[ex_idx] + 2'b01;
                end
            end else begin
                if (bht[ex_idx] != 2'b00) begin
                    bht[ex_idx] <= bht[ex_idx] - 2'b01;
                end
            end
        end
    end

endmodule
